muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller with its own datapath, serving the EX stage of the 54-instruction pipeline CPU. It accepts MULT/MULTU/DIV/DIVU operands from EX and runs a 32-step shift-add or restoring shift-subtract sequence. While it is busy it stalls the pipeline. It then presents HI/LO results for a single cycle so the instruction can advance with HI/LO write data.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Used by the sequencer, its step logic and the EX/WB HI/LO decode.
package muldiv_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    // HI write-data source as decoded by EX and writeback
    typedef enum logic [1:0] {
        HI_SEL_DIV_R,
        HI_SEL_MUL_HI,
        HI_SEL_RS
    } hi_sel_t;

    // LO write-data source as decoded by EX and writeback
    typedef enum logic [1:0] {
        LO_SEL_DIV_Q,
        LO_SEL_MUL_LO,
        LO_SEL_RS
    } lo_sel_t;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide)
// iteration over the {acc/rem, mplier/dvd} register pair.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             op_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nx,
    output logic [WIDTH-1:0] low_nx
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Single iteration; 33-bit sum/remainder keep the carry out
    always_comb begin
        addend = low[0] ? opnd : '0;
        sum    = {1'b0, acc} + {1'b0, addend};
        rem_sh = {acc, low[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd};
        acc_nx = sum[WIDTH:1];
        low_nx = {sum[0], low[WIDTH-1:1]};
        if (op_div) begin
            if (rem_sh >= {1'b0, opnd}) begin
                acc_nx = diff[WIDTH-1:0];
                low_nx = {low[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh[WIDTH-1:0];
                low_nx = {low[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller for the EX stage.
// Stalls the pipe while running and pulses done with HI/LO results.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             op_div_r;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] low_nx;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             load;
    logic             fix;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign a_mag = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign busy_out = (state != IDLE);
    assign done_out = (state == DONE);

    // Sign fix-up of the raw magnitude results
    always_comb begin
        prod = {acc, low};
        quo  = low;
        rem  = acc;
        if (neg_q) begin
            prod = ~prod + 1'b1;
            quo  = ~quo + 1'b1;
        end
        if (neg_r) begin
            rem = ~rem + 1'b1;
        end
    end

    // Next state, launch/fix enables and pipeline stall
    always_comb begin
        state_nx  = state;
        stall_out = 1'b0;
        load      = 1'b0;
        fix       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !flush) begin
                    state_nx  = RUN;
                    load      = 1'b1;
                    stall_out = 1'b1;
                end
            end
            RUN: begin
                stall_out = 1'b1;
                if (cnt == '0) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                stall_out = 1'b1;
                fix       = !flush;
                state_nx  = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand latch, iteration and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            op_div_r <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            a_raw    <= '0;
            acc      <= '0;
            low      <= '0;
            opnd     <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else if (load) begin
            cnt      <= CNT_TOP;
            op_div_r <= op_div;
            neg_q    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= sign & a[WIDTH-1];
            dz       <= op_div && (b == '0);
            a_raw    <= a;
            acc      <= '0;
            low      <= op_div ? a_mag : b_mag;
            opnd     <= op_div ? b_mag : a_mag;
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            acc <= acc_nx;
            low <= low_nx;
        end else if (fix) begin
            if (!op_div_r) begin
                hi_out <= prod[2*WIDTH-1:WIDTH];
                lo_out <= prod[WIDTH-1:0];
            end else if (dz) begin
                hi_out <= a_raw;
                lo_out <= '1;
            end else begin
                hi_out <= rem;
                lo_out <= quo;
            end
        end
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op_div(op_div_r),
        .acc   (acc),
        .low   (low),
        .opnd  (opnd),
        .acc_nx(acc_nx),
        .low_nx(low_nx)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: arithmetic reference model with per-cycle
// compare, plus directed literal cases for the listed corner values.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        stall_out;
    logic        busy_out;
    logic        done_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int vec = 0;
    int fail = 0;

    // model state: cycles since launch, pending and visible results
    bit          m_busy = 0;
    int          m_t = 0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_div   (op_div),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .stall_out(stall_out),
        .busy_out (busy_out),
        .done_out (done_out),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(input bit d, input bit s,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] up;
        sx = s ? longint'($signed(x)) : longint'({32'b0, x});
        sy = s ? longint'($signed(y)) : longint'({32'b0, y});
        if (d) begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
        if (s) begin
            p = sx * sy;
            return p;
        end
        up = {32'b0, x} * {32'b0, y};
        return up;
    endfunction

    // Behavioural model advanced on each clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0;
            m_t = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (!m_busy) begin
            if (start && !flush) begin
                m_busy = 1;
                m_t = 0;
                m_res = ref_res(op_div, sign, a, b);
            end
        end else if (flush) begin
            m_busy = 0;
        end else begin
            m_t++;
            if (m_t == 33) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
            if (m_t == 34) m_busy = 0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic e_stall, e_busy, e_done;
        e_busy  = m_busy;
        e_done  = m_busy && (m_t == 33);
        e_stall = (!m_busy && start && !flush) || (m_busy && m_t < 33);
        vec++;
        if ({stall_out, busy_out, done_out, hi_out, lo_out} !==
            {e_stall, e_busy, e_done, m_hi, m_lo}) begin
            fail++;
            $display("FAIL cycle t=%0t dut s/b/d=%b%b%b hi=%h lo=%h exp s/b/d=%b%b%b hi=%h lo=%h",
                     $time, stall_out, busy_out, done_out, hi_out, lo_out,
                     e_stall, e_busy, e_done, m_hi, m_lo);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input bit d, input bit s, input logic [31:0] x,
                         input logic [31:0] y);
        op_div = d;
        sign = s;
        a = x;
        b = y;
        start = 1'b1;
        #1;
        chk("stall_at_issue", {31'b0, stall_out}, 32'd1);
        cyc();
        start = 1'b0;
    endtask

    task automatic run_lit(input string nm, input bit d, input bit s,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el);
        int n;
        issue(d, s, x, y);
        n = 0;
        while (!done_out && n < 60) begin
            cyc();
            n++;
        end
        chk({nm, "_latency"}, n, 33);
        chk({nm, "_hi"}, hi_out, eh);
        chk({nm, "_lo"}, lo_out, el);
        cyc();
    endtask

    initial begin
        int dones;
        logic [31:0] corner [8];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                   32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h0001_0000};

        #12;
        chk("reset_hi", hi_out, 0);
        chk("reset_lo", lo_out, 0);
        chk("reset_flags", {29'b0, stall_out, busy_out, done_out}, 0);
        rst = 1'b1;
        cyc();

        run_lit("divu", 1, 0, 100, 7, 2, 14);
        run_lit("div_neg", 1, 1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_lit("mult_neg", 0, 1, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_lit("multu_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        run_lit("div_ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        run_lit("div_zero_s", 1, 1, 32'h1234_5678, 0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_lit("divu_zero", 1, 0, 32'h1234_5678, 0, 32'h1234_5678, 32'hFFFF_FFFF);

        // flush at iteration 10, then immediate restart
        issue(1, 0, 50, 5);
        repeat (10) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_stall", {31'b0, stall_out}, 0);
        chk("flush_hi_kept", hi_out, 32'h1234_5678);
        chk("flush_lo_kept", lo_out, 32'hFFFF_FFFF);
        run_lit("after_flush", 1, 0, 9, 3, 0, 3);

        // asynchronous reset mid-run
        issue(0, 0, 123, 456);
        repeat (5) cyc();
        rst = 1'b0;
        #1;
        chk("arst_flags", {29'b0, stall_out, busy_out, done_out}, 0);
        chk("arst_hi", hi_out, 0);
        chk("arst_lo", lo_out, 0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        run_lit("after_rst", 0, 0, 123, 456, 0, 56088);

        // second start while busy is ignored
        issue(1, 0, 1000, 10);
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            start = (i == 3 || i == 4);
            if (done_out) dones++;
            cyc();
        end
        start = 1'b0;
        chk("single_done", dones, 1);
        chk("busy_start_lo", lo_out, 100);

        // randomized operations against the model
        for (int k = 0; k < 300; k++) begin
            int n;
            bit fl;
            op_div = $urandom_range(0, 1);
            sign = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            flush = ($urandom_range(0, 15) == 0);
            start = 1'b1;
            cyc();
            start = 1'b0;
            flush = 1'b0;
            fl = ($urandom_range(0, 4) == 0);
            n = 0;
            while (m_busy && n < 60) begin
                start = ($urandom_range(0, 7) == 0);
                flush = fl && ($urandom_range(0, 20) == 0);
                cyc();
                n++;
            end
            start = 1'b0;
            flush = 1'b0;
            if (m_busy) begin
                fail++;
                $display("FAIL timeout op=%0d", k);
            end
            repeat ($urandom_range(0, 2)) cyc();
        end

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
        $finish;
    end

endmodule
